// File: rtl/conv3d_fwd_asym_kernel_engine.sv
// Forward 3D convolution engine with an asymmetric kernel.
// Loads a volume and kernel, then gathers each output voxel with one serial MAC.
module conv3d_fwd_asym_kernel_engine #(
  parameter int D  = 4,
  parameter int H  = 4,
  parameter int W  = 4,
  parameter int KD = 3,
  parameter int KH = 2,
  parameter int KW = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid_in,
  input  logic [31:0] input_data,
  input  logic [31:0] weight_data,
  output logic        in_ready,
  output logic        valid_out,
  input  logic        ready_out,
  output logic [31:0] output_data,
  output logic        done
);

  localparam int OD = D - KD + 1;
  localparam int OH = H - KH + 1;
  localparam int OW = W - KW + 1;
  localparam int NI = D * H * W;
  localparam int NK = KD * KH * KW;
  localparam int NO = OD * OH * OW;
  localparam int AW = (NI > 1) ? $clog2(NI) : 1;
  localparam int TW = (NK > 1) ? $clog2(NK) : 1;

  localparam logic signed [63:0] SAT_MAX = 64'sh0000_0000_7FFF_FFFF;
  localparam logic signed [63:0] SAT_MIN = -64'sh0000_0000_8000_0000;

  typedef enum logic [1:0] {
    S_LOAD,
    S_COMPUTE,
    S_EMIT
  } state_e;

  state_e state_q, state_d;

  logic [AW-1:0] ld_cnt_q, ld_cnt_d;
  logic [AW-1:0] kd_q, kd_d;
  logic [AW-1:0] kh_q, kh_d;
  logic [AW-1:0] kw_q, kw_d;
  logic [TW-1:0] t_q, t_d;
  logic [AW-1:0] od_q, od_d;
  logic [AW-1:0] oh_q, oh_d;
  logic [AW-1:0] ow_q, ow_d;

  logic signed [63:0] acc_q, acc_d;
  logic signed [63:0] prod;
  logic [31:0]        out_q, out_d;
  logic               valid_q, valid_d;
  logic               done_q, done_d;

  logic signed [31:0] in_mem [NI];
  logic signed [31:0] w_mem  [NK];

  logic [AW-1:0] rd_addr;
  logic          in_we;
  logic          w_we;
  logic          last_tap;
  logic          last_out;

  function automatic logic [31:0] sat32(input logic signed [63:0] v);
    logic [31:0] r;
    if (v > SAT_MAX) begin
      r = 32'h7FFF_FFFF;
    end else if (v < SAT_MIN) begin
      r = 32'h8000_0000;
    end else begin
      r = v[31:0];
    end
    return r;
  endfunction

  assign in_ready    = (state_q == S_LOAD);
  assign valid_out   = valid_q;
  assign output_data = out_q;
  assign done        = done_q;

  // Gather address of the current tap and its signed product.
  always_comb begin
    rd_addr = AW'(((int'(od_q) + int'(kd_q)) * H
                   + int'(oh_q) + int'(kh_q)) * W
                  + int'(ow_q) + int'(kw_q));
    prod = 64'(in_mem[rd_addr]) * 64'(w_mem[t_q]);
    last_tap = (int'(t_q) == NK - 1);
    last_out = (int'(od_q) == OD - 1)
            && (int'(oh_q) == OH - 1)
            && (int'(ow_q) == OW - 1);
  end

  // Next-state and datapath control for the load/compute/emit sequence.
  always_comb begin
    state_d  = state_q;
    ld_cnt_d = ld_cnt_q;
    kd_d     = kd_q;
    kh_d     = kh_q;
    kw_d     = kw_q;
    t_d      = t_q;
    od_d     = od_q;
    oh_d     = oh_q;
    ow_d     = ow_q;
    acc_d    = acc_q;
    out_d    = out_q;
    valid_d  = valid_q;
    done_d   = 1'b0;
    in_we    = 1'b0;
    w_we     = 1'b0;
    case (state_q)
      S_LOAD: begin
        if (valid_in) begin
          in_we = 1'b1;
          w_we  = (int'(ld_cnt_q) < NK);
          if (int'(ld_cnt_q) == NI - 1) begin
            ld_cnt_d = '0;
            state_d  = S_COMPUTE;
            od_d     = '0;
            oh_d     = '0;
            ow_d     = '0;
            kd_d     = '0;
            kh_d     = '0;
            kw_d     = '0;
            t_d      = '0;
          end else begin
            ld_cnt_d = ld_cnt_q + 1'b1;
          end
        end
      end
      S_COMPUTE: begin
        acc_d = (t_q == '0) ? prod : acc_q + prod;
        if (last_tap) begin
          kd_d    = '0;
          kh_d    = '0;
          kw_d    = '0;
          t_d     = '0;
          out_d   = sat32(acc_d);
          valid_d = 1'b1;
          state_d = S_EMIT;
        end else begin
          t_d = t_q + 1'b1;
          if (int'(kw_q) == KW - 1) begin
            kw_d = '0;
            if (int'(kh_q) == KH - 1) begin
              kh_d = '0;
              kd_d = kd_q + 1'b1;
            end else begin
              kh_d = kh_q + 1'b1;
            end
          end else begin
            kw_d = kw_q + 1'b1;
          end
        end
      end
      S_EMIT: begin
        if (ready_out) begin
          valid_d = 1'b0;
          if (last_out) begin
            done_d  = 1'b1;
            state_d = S_LOAD;
          end else begin
            state_d = S_COMPUTE;
            if (int'(ow_q) == OW - 1) begin
              ow_d = '0;
              if (int'(oh_q) == OH - 1) begin
                oh_d = '0;
                od_d = od_q + 1'b1;
              end else begin
                oh_d = oh_q + 1'b1;
              end
            end else begin
              ow_d = ow_q + 1'b1;
            end
          end
        end
      end
      default: begin
        state_d = S_LOAD;
      end
    endcase
  end

  // Control and datapath registers; reset aborts any operation in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_LOAD;
      ld_cnt_q <= '0;
      kd_q     <= '0;
      kh_q     <= '0;
      kw_q     <= '0;
      t_q      <= '0;
      od_q     <= '0;
      oh_q     <= '0;
      ow_q     <= '0;
      acc_q    <= '0;
      out_q    <= '0;
      valid_q  <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      ld_cnt_q <= ld_cnt_d;
      kd_q     <= kd_d;
      kh_q     <= kh_d;
      kw_q     <= kw_d;
      t_q      <= t_d;
      od_q     <= od_d;
      oh_q     <= oh_d;
      ow_q     <= ow_d;
      acc_q    <= acc_d;
      out_q    <= out_d;
      valid_q  <= valid_d;
      done_q   <= done_d;
    end
  end

  // Volume and kernel storage; contents survive reset and are rewritten on load.
  always_ff @(posedge clk) begin
    if (in_we) begin
      in_mem[ld_cnt_q] <= input_data;
    end
    if (w_we) begin
      w_mem[TW'(ld_cnt_q)] <= weight_data;
    end
  end

endmodule

// File: tb/tb_conv3d_fwd_asym_kernel_engine.sv
// Bench for conv3d_fwd_asym_kernel_engine.
// Random and directed volumes checked against a plain-arithmetic convolution model.
module tb_conv3d_fwd_asym_kernel_engine;

  localparam int D  = 4;
  localparam int H  = 4;
  localparam int W  = 4;
  localparam int KD = 3;
  localparam int KH = 2;
  localparam int KW = 2;
  localparam int OD = D - KD + 1;
  localparam int OH = H - KH + 1;
  localparam int OW = W - KW + 1;
  localparam int NI = D * H * W;
  localparam int NK = KD * KH * KW;
  localparam int NO = OD * OH * OW;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_in;
  logic [31:0] input_data;
  logic [31:0] weight_data;
  logic        in_ready;
  logic        valid_out;
  logic        ready_out;
  logic [31:0] output_data;
  logic        done;

  int n_assert = 0;
  int n_fail   = 0;

  logic [31:0] vin [NI];
  logic [31:0] wt  [NK];
  logic [31:0] exp_o [NO];

  conv3d_fwd_asym_kernel_engine #(
    .D(D), .H(H), .W(W), .KD(KD), .KH(KH), .KW(KW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .valid_in(valid_in),
    .input_data(input_data),
    .weight_data(weight_data),
    .in_ready(in_ready),
    .valid_out(valid_out),
    .ready_out(ready_out),
    .output_data(output_data),
    .done(done)
  );

  always #5 clk = ~clk;

  function automatic void model();
    longint s;
    longint a;
    longint b;
    int     o;
    o = 0;
    for (int od = 0; od < OD; od++)
      for (int oh = 0; oh < OH; oh++)
        for (int ow = 0; ow < OW; ow++) begin
          s = 0;
          for (int kd = 0; kd < KD; kd++)
            for (int kh = 0; kh < KH; kh++)
              for (int kw = 0; kw < KW; kw++) begin
                a = longint'($signed(vin[((od + kd) * H + oh + kh) * W + ow + kw]));
                b = longint'($signed(wt[(kd * KH + kh) * KW + kw]));
                s = s + a * b;
              end
          if (s > 64'sd2147483647) exp_o[o] = 32'h7FFF_FFFF;
          else if (s < -64'sd2147483648) exp_o[o] = 32'h8000_0000;
          else exp_o[o] = s[31:0];
          o++;
        end
  endfunction

  task automatic fill(input logic [31:0] iv, input logic [31:0] wv);
    for (int i = 0; i < NI; i++) vin[i] = iv;
    for (int i = 0; i < NK; i++) wt[i] = wv;
  endtask

  task automatic fill_rand(input int lo, input int hi);
    for (int i = 0; i < NI; i++) vin[i] = 32'($urandom_range(0, hi - lo) + lo);
    for (int i = 0; i < NK; i++) wt[i] = 32'($urandom_range(0, hi - lo) + lo);
  endtask

  // Streams the volume; returns just after the edge that takes the final beat.
  task automatic load(input bit gaps);
    for (int i = 0; i < NI; i++) begin
      if (gaps) begin
        while ($urandom_range(0, 2) == 0) begin
          @(negedge clk);
          valid_in    = 1'b0;
          input_data  = $urandom;
          weight_data = $urandom;
        end
      end
      @(negedge clk);
      valid_in    = 1'b1;
      input_data  = vin[i];
      weight_data = (i < NK) ? wt[i] : $urandom;
    end
    @(posedge clk);
  endtask

  // The final load beat is cycle 0; cycles count up from the edge that takes it.
  task automatic collect(input string nm, input int stall,
                         input bit rnd, input bit junk);
    int cyc, idx, hs, dones, stalled, want;
    bit seen;
    logic [31:0] held;
    cyc = 1; idx = 0; hs = -1; dones = 0; stalled = 0; seen = 1'b0;
    held = '0;
    while (!(idx == NO && cyc >= hs + 3) && cyc < 3000) begin
      @(negedge clk);
      valid_in    = junk && (idx < NO);
      input_data  = $urandom;
      weight_data = $urandom;
      if (cyc == 1) begin
        n_assert++;
        if (in_ready !== 1'b0) begin
          n_fail++;
          $display("FAIL %s in_ready_after_load got=%b want=0", nm, in_ready);
        end
      end
      if (done === 1'b1) begin
        dones++;
        n_assert++;
        if (!(idx == NO && cyc == hs + 1 && in_ready === 1'b1
              && valid_out === 1'b0)) begin
          n_fail++;
          $display("FAIL %s done_pulse cyc=%0d idx=%0d in_ready=%b valid=%b want cyc=%0d idx=%0d",
                   nm, cyc, idx, in_ready, valid_out, hs + 1, NO);
        end
      end
      if (valid_out === 1'b1) begin
        if (!seen) begin
          seen = 1'b1;
          held = output_data;
          stalled = 0;
          want = (idx == 0) ? NK + 1 : hs + NK + 1;
          n_assert++;
          if (cyc != want) begin
            n_fail++;
            $display("FAIL %s latency out=%0d cyc=%0d want=%0d", nm, idx, cyc, want);
          end
        end else begin
          n_assert++;
          if (output_data !== held) begin
            n_fail++;
            $display("FAIL %s hold out=%0d got=%h want=%h", nm, idx, output_data, held);
          end
        end
        if (idx == 0 && stalled < stall) begin
          ready_out = 1'b0;
          stalled++;
        end else begin
          ready_out = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        end
        if (ready_out) begin
          n_assert++;
          if (idx >= NO || output_data !== exp_o[idx]) begin
            n_fail++;
            $display("FAIL %s data out=%0d got=%h want=%h", nm, idx, output_data,
                     (idx < NO) ? exp_o[idx] : 32'hx);
          end
          idx++;
          hs = cyc;
          seen = 1'b0;
        end
      end else begin
        if (seen) begin
          n_assert++;
          n_fail++;
          $display("FAIL %s valid_dropped out=%0d cyc=%0d got=0 want=1", nm, idx, cyc);
          seen = 1'b0;
        end
        ready_out = 1'($urandom_range(0, 1));
      end
      @(posedge clk);
      cyc++;
    end
    valid_in  = 1'b0;
    ready_out = 1'b0;
    n_assert++;
    if (idx != NO) begin
      n_fail++;
      $display("FAIL %s output_count got=%0d want=%0d", nm, idx, NO);
    end
    n_assert++;
    if (dones != 1) begin
      n_fail++;
      $display("FAIL %s done_count got=%0d want=1", nm, dones);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    valid_in = 1'b0;
    ready_out = 1'b0;
    input_data = '0;
    weight_data = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_assert++;
    if (in_ready !== 1'b1 || valid_out !== 1'b0
        || output_data !== 32'h0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_values got rdy=%b vld=%b data=%h done=%b want 1 0 0 0",
               in_ready, valid_out, output_data, done);
    end
    rst = 1'b0;
    @(negedge clk);
    n_assert++;
    if (in_ready !== 1'b1 || valid_out !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_release got rdy=%b vld=%b want 1 0", in_ready, valid_out);
    end
  endtask

  task automatic test_ones();
    fill(32'd1, 32'd1);
    model();
    load(1'b0);
    collect("ones", 0, 1'b0, 1'b0);
  endtask

  task automatic test_index();
    for (int i = 0; i < NI; i++) vin[i] = 32'(i);
    for (int i = 0; i < NK; i++) wt[i] = (i == 0) ? 32'd1 : 32'd0;
    model();
    load(1'b0);
    collect("index", 0, 1'b0, 1'b0);
  endtask

  task automatic test_saturation();
    fill(32'h7FFF_FFFF, 32'd1);
    model();
    load(1'b0);
    collect("sat_pos", 0, 1'b0, 1'b0);
    fill(32'h8000_0000, 32'd1);
    model();
    load(1'b0);
    collect("sat_neg", 0, 1'b0, 1'b0);
    fill(-32'sd3, 32'sd2);
    model();
    load(1'b0);
    collect("neg3x2", 0, 1'b0, 1'b0);
  endtask

  task automatic test_backpressure();
    fill_rand(-1000, 1000);
    model();
    load(1'b0);
    collect("stall5", 5, 1'b0, 1'b0);
    fill_rand(-50000, 50000);
    model();
    load(1'b0);
    collect("rand_ready", 3, 1'b1, 1'b0);
  endtask

  task automatic test_gaps_junk();
    fill_rand(-30000, 30000);
    model();
    load(1'b1);
    collect("gaps_junk", 0, 1'b1, 1'b1);
  endtask

  task automatic test_full_range();
    for (int i = 0; i < NI; i++) vin[i] = $urandom;
    for (int i = 0; i < NK; i++) wt[i] = $urandom;
    model();
    load(1'b1);
    collect("full_range", 0, 1'b1, 1'b0);
  endtask

  task automatic test_reset_mid();
    int k;
    int guard;
    fill_rand(-100, 100);
    model();
    load(1'b0);
    k = 0;
    guard = 0;
    while (k < 5 && guard < 500) begin
      @(negedge clk);
      valid_in  = 1'b0;
      ready_out = 1'b1;
      if (valid_out === 1'b1) k++;
      @(posedge clk);
      guard++;
    end
    n_assert++;
    if (k != 5) begin
      n_fail++;
      $display("FAIL reset_mid_reach got=%0d want=5", k);
    end
    repeat (4) @(posedge clk);
    @(negedge clk);
    ready_out = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    n_assert++;
    if (valid_out !== 1'b0 || in_ready !== 1'b1 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid_abort got vld=%b rdy=%b done=%b want 0 1 0",
               valid_out, in_ready, done);
    end
    @(negedge clk);
    rst = 1'b0;
    fill_rand(-20000, 20000);
    model();
    load(1'b0);
    collect("after_reset", 0, 1'b0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_ones();
    test_index();
    test_saturation();
    test_backpressure();
    test_gaps_junk();
    test_full_range();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/conv3d_fwd_asym_kernel_engine.md
Name: conv3d_fwd_asym_kernel_engine

Overview:
- Sequential forward (gathering) 3D convolution engine; the adjoint of the transposed-3D-convolution (scatter) block in the same operator library.
- Loads one single-channel input volume and one asymmetric kernel over a valid-only stream.
- Computes each output voxel with a single serial MAC and streams results out under valid/ready backpressure.
- Stride 1, padding 0, one input channel and one output channel, no bias.

Parameters:
- D, 4: input depth.
- H, 4: input height.
- W, 4: input width.
- KD, 3: kernel depth.
- KH, 2: kernel height.
- KW, 2: kernel width.
- Derived, not overridable: OD=D-KD+1, OH=H-KH+1, OW=W-KW+1, NI=D*H*W, NK=KD*KH*KW, NO=OD*OH*OW.
- Legal configurations require NK<=NI and every kernel dimension to be no larger than the matching input dimension.

Ports:
- clk, in, 1: single clock; all logic is on its rising edge.
- rst, in, 1: asynchronous, active-high reset.
- valid_in, in, 1: load beat qualifier; sampled only when in_ready=1.
- input_data, in, 32: signed input voxel, raster order d,h,w (w fastest).
- weight_data, in, 32: signed kernel tap, raster order kd,kh,kw; captured on the first NK load beats only.
- in_ready, out, 1: high in LOAD state.
- valid_out, out, 1: output voxel valid.
- ready_out, in, 1: downstream accept.
- output_data, out, 32: signed saturated result, raster order od,oh,ow.
- done, out, 1: one-cycle pulse after the last output is accepted.

Behaviour:
- Reset values: in_ready=1, valid_out=0, output_data=0, done=0. All counters and the accumulator are 0. State is LOAD.
- Reset applied mid-operation aborts immediately: the state returns to LOAD and partial results are discarded.
- Memory contents are not cleared by reset; they are fully rewritten on the next load.
- LOAD state:
  - Each cycle with valid_in=1 writes input_data to in_mem[ld_cnt].
  - If ld_cnt<NK, the same cycle also writes weight_data to w_mem[ld_cnt].
  - ld_cnt increments on each accepted beat.
  - On the beat where ld_cnt=NI-1: ld_cnt clears, in_ready deasserts the next cycle, state goes to COMPUTE with the output index at (0,0,0).
  - valid_in=0 leaves everything unchanged.
- COMPUTE state:
  - One tap per cycle, tap index t=0..NK-1 decomposed as (kd,kh,kw).
  - Reads in_mem[((od+kd)*H+(oh+kh))*W+(ow+kw)] and w_mem[t]; both memory reads are combinational.
  - At t=0: acc <= product. Otherwise: acc <= acc + product.
  - Product is the signed 32x32 -> 64-bit result. acc is 64-bit signed and wraps on overflow.
  - After tap NK-1, state goes to EMIT.
- EMIT state:
  - Entering EMIT, output_data takes the saturated acc: values >0x7FFFFFFF clamp to 0x7FFFFFFF, values <-2^31 clamp to 0x80000000.
  - valid_out=1.
  - output_data and valid_out hold stable while ready_out=0.
  - On valid_out&&ready_out: if this is the last output, done pulses on the next cycle, valid_out drops, and state goes to LOAD. Otherwise the output index advances (ow fastest, wrapping to 0 and carrying into oh, then od) and state goes to COMPUTE.
- Latency:
  - First valid_out occurs NK+1 cycles after the final load beat.
  - With ready_out held high, one output is produced every NK+1 cycles.
  - Total compute time is NO*(NK+1) cycles.
- valid_in while not in LOAD is ignored: no write and no counter change.
- ready_out outside EMIT is ignored.
- done and in_ready may both be 1 in the same cycle (the first LOAD cycle).

Test Plan:
- Defaults; all 64 inputs=1, all 12 weights=1, ready_out=1 -> 18 outputs each 12; first valid_out 13 cycles after the last load beat; done pulse once.
- Inputs = index 0..63, w[0]=1, others 0 -> outputs equal in_mem[(od*4+oh)*4+ow]: 0,1,2,4,5,6,8,9,10,16,17,18,20,21,22,24,25,26.
- Inputs=0x7FFFFFFF, weights=1 -> all outputs 0x7FFFFFFF. Inputs=0x80000000, weights=1 -> all outputs 0x80000000. Inputs=-3, weights=2 -> all outputs -72.
- ready_out held low 5 cycles during the first EMIT -> valid_out stays 1 and output_data is unchanged; the next output starts only after the handshake.
- valid_in toggled with gaps during load, plus valid_in=1 during COMPUTE -> results match the gap-free run; the extra beats are ignored.
- rst asserted in the middle of COMPUTE of output 5 -> next edge: valid_out=0, in_ready=1, done=0. A full reload then produces correct results from output 0.
